// File: rtl/lbp_pkg.sv
// Shared constants, FSM state encoding and pixel-address helper for the LBP histogram.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int CODE_W = 8;
    localparam int NBINS  = 256;
    localparam int ADDR_W = 14;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A 3x3 LBP code needs all eight neighbours, so the outer ring of the
    // frame (row/col 0 and img_w-1) never carries a meaningful code.
    function automatic logic is_interior(input logic [ADDR_W-1:0] addr, input int img_w);
        int unsigned w;
        int unsigned row;
        int unsigned col;
        w   = img_w;
        row = 32'(addr) / w;
        col = 32'(addr) % w;
        return (row >= 1) && (row <= w - 2) && (col >= 1) && (col <= w - 2);
    endfunction

endpackage

// File: rtl/lbp_hist_bank.sv
// 256-entry flop array of saturating bin counters: increment port, read mux, clear-on-index port.
// Latency: increment and clear land on the next edge; read is combinational.
// Backpressure: none; caller sequences increment (accumulate) and clear (drain) phases.
//
// Ports: clk, reset (async, active-low), inc_en/inc_idx (bump one bin),
//        clr_en/clr_idx (zero one bin), rd_idx -> rd_count (combinational read).
module lbp_hist_bank
    import lbp_pkg::*;
#(
    parameter int CNT_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc_en,
    input  logic [CODE_W-1:0] inc_idx,
    input  logic              clr_en,
    input  logic [CODE_W-1:0] clr_idx,
    input  logic [CODE_W-1:0] rd_idx,
    output logic [CNT_W-1:0]  rd_count
);

    logic [NBINS-1:0][CNT_W-1:0] bins_flat;

    for (genvar g = 0; g < NBINS; g++) begin : g_bin
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (clr_en && (clr_idx == CODE_W'(g))) begin
                cnt <= '0;
            end else if (inc_en && (inc_idx == CODE_W'(g)) && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign bins_flat[g] = cnt;
    end

    assign rd_count = bins_flat[rd_idx];

endmodule

// File: rtl/lbp_hist.sv
// Accumulates a 256-bin histogram of LBP codes per frame, drains it on a valid/ready stream, reports peak and total.
// Latency: code to bin update 2 edges; finish rise to first hist_valid 2 cycles (3 if a code rides with the rise).
// Backpressure: hist_ready stalls the drain with hist_bin/hist_count held; input has no backpressure, codes are dropped with in_err.
//
// Ports: clk, reset (async, active-low); lbp_valid/lbp_addr/lbp_data code input;
//        finish (level, rising edge closes the frame); hist_valid/hist_ready/hist_bin/
//        hist_count/hist_last drain stream; total_count, peak_code, peak_count,
//        in_err (dropped-code pulse), done (drain complete).
module lbp_hist #(
    parameter int CNT_W = 14,
    parameter int IMG_W = lbp_pkg::IMG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_last,
    output logic [15:0]      total_count,
    output logic [7:0]       peak_code,
    output logic [CNT_W-1:0] peak_count,
    output logic             in_err,
    output logic             done
);
    import lbp_pkg::*;

    state_t           state;
    logic             finish_d;
    logic             fin_rise;
    logic             fin_pend;
    logic             s1_vld;
    logic [7:0]       s1_code;
    logic [7:0]       index;
    logic [CNT_W-1:0] rd_count;
    logic             addr_ok;
    logic             accept;
    logic             drain_hs;

    assign fin_rise = finish & ~finish_d;
    assign addr_ok  = is_interior(lbp_addr, IMG_W);

    // Once the frame-end edge has been seen, a late code would land in a frame
    // that is already closing, so it is dropped like any other rejected code.
    // In DONE an interior code opens the next frame and is counted.
    assign accept   = lbp_valid && addr_ok &&
                      (((state == ST_ACCUM) && !fin_pend) || (state == ST_DONE));
    assign drain_hs = (state == ST_DRAIN) && hist_ready;

    assign hist_valid = (state == ST_DRAIN);
    assign hist_bin   = index;
    assign hist_count = hist_valid ? rd_count : '0;
    assign hist_last  = hist_valid && (index == 8'hFF);
    assign done       = (state == ST_DONE);

    lbp_hist_bank #(
        .CNT_W (CNT_W)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (s1_vld),
        .inc_idx  (s1_code),
        .clr_en   (drain_hs),
        .clr_idx  (index),
        .rd_idx   (index),
        .rd_count (rd_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_ACCUM;
            finish_d    <= 1'b0;
            fin_pend    <= 1'b0;
            s1_vld      <= 1'b0;
            s1_code     <= '0;
            index       <= '0;
            total_count <= '0;
            peak_code   <= '0;
            peak_count  <= '0;
            in_err      <= 1'b0;
        end else begin
            finish_d <= finish;
            s1_vld   <= accept;
            if (accept) begin
                s1_code <= lbp_data;
            end
            in_err <= lbp_valid && !accept;

            if (s1_vld && (total_count != 16'hFFFF)) begin
                total_count <= total_count + 1'b1;
            end

            case (state)
                ST_ACCUM: begin
                    if (fin_rise) begin
                        fin_pend <= 1'b1;
                    end
                    // Wait for s1 to drain so the last increment lands before bin 0 is shown.
                    if (fin_pend && !s1_vld) begin
                        state    <= ST_DRAIN;
                        fin_pend <= 1'b0;
                        index    <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (hist_ready) begin
                        // Strictly greater: on a tie the earlier (lower) code keeps the peak.
                        if (rd_count > peak_count) begin
                            peak_code  <= index;
                            peak_count <= rd_count;
                        end
                        index <= index + 1'b1;
                        if (index == 8'hFF) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (accept) begin
                        state       <= ST_ACCUM;
                        total_count <= '0;
                        peak_code   <= '0;
                        peak_count  <= '0;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule
